// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : bus_pkg                                                  |
// | Purpose   : Shared constants, encodings and FSM state type for the   |
// |             on-chip peripheral bus (cs_/as_/rw/addr/rdy_).           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package bus_pkg;

  // Transfer direction as driven on rw lines
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Active-low strobe / select levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Bus geometry
  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 32;
  localparam int SLV_SEL_W = 3;
  localparam int NUM_SLV   = 1 << SLV_SEL_W;

  // Width of the optional wait counter
  localparam int WAIT_CNT_W = 8;

  // Initiator FSM states
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_initiator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : bus_initiator_if                                         |
// | Purpose   : Core request/response port plus peripheral bus signals.  |
// |             master = initiator view, slave = core + bus environment. |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface bus_initiator_if;
  import bus_pkg::*;

  // Core side
  logic                req;
  logic                req_rw;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wr_data;
  logic                req_busy;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rd_data;
  logic                resp_err;

  // Bus side
  logic [NUM_SLV-1:0]  bus_cs_;
  logic                bus_as_;
  logic                bus_rw;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wr_data;
  logic [DATA_W-1:0]   bus_rd_data;
  logic                bus_rdy_;

  modport master (
    input  req, req_rw, req_addr, req_wr_data, bus_rd_data, bus_rdy_,
    output req_busy, resp_valid, resp_rd_data, resp_err,
           bus_cs_, bus_as_, bus_rw, bus_addr, bus_wr_data
  );

  modport slave (
    output req, req_rw, req_addr, req_wr_data, bus_rd_data, bus_rdy_,
    input  req_busy, resp_valid, resp_rd_data, resp_err,
           bus_cs_, bus_as_, bus_rw, bus_addr, bus_wr_data
  );

endinterface
`default_nettype wire

// File: rtl/bus_addr_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : bus_addr_dec                                             |
// | Purpose   : Slave index to one-hot-cold active-low chip-select       |
// |             vector; all selects inactive when disabled.              |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module bus_addr_dec
  import bus_pkg::*;
(
  input  logic                 en,
  input  logic [SLV_SEL_W-1:0] idx,
  output logic [NUM_SLV-1:0]   cs_
);

  // Full decode: every index selects exactly one slave
  always_comb begin
    cs_ = {NUM_SLV{DISABLE_}};
    if (en) cs_[idx] = ENABLE_;
  end

endmodule
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : bus_initiator                                            |
// | Purpose   : Bus master for the on-chip peripheral bus. Accepts one   |
// |             core word request, decodes the chip-select, holds the    |
// |             strobe until the slave returns rdy_, returns read data.  |
// | Options   : BUS_TIMEOUT_EN - abort after TIMEOUT_CYC wait cycles     |
// |             and flag resp_err; otherwise wait indefinitely.          |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module bus_initiator
  import bus_pkg::*;
`ifdef BUS_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 255
)
`endif
(
  input  logic            clk,
  input  logic            reset,
  bus_initiator_if.master bif
);

  state_t              state, state_n;
  logic [NUM_SLV-1:0]  dec_cs_;
  logic                accept, done, abort;

  logic                as_q, as_n;
  logic [NUM_SLV-1:0]  cs_q, cs_n;
  logic                rw_q, rw_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wd_q, wd_n;
  logic                busy_q, busy_n;
  logic                rv_q, rv_n;
  logic [DATA_W-1:0]   rd_q, rd_n;
  logic                err_q, err_n;

  // In IDLE req_busy is low, so a request there is always taken
  assign accept = (state == ST_IDLE) && bif.req;
  assign done   = (state == ST_ACCESS) && (bif.bus_rdy_ == ENABLE_);

`ifdef BUS_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt;

  // Count ACCESS cycles in which the slave has not answered
  always_ff @(posedge clk) begin
    if (reset || accept)
      wait_cnt <= '0;
    else if ((state == ST_ACCESS) && (bif.bus_rdy_ == DISABLE_))
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Abort on the edge that would make the count reach TIMEOUT_CYC; a
  // simultaneous rdy_ is not an abort because rdy_ must be high here
  assign abort = (state == ST_ACCESS) && (bif.bus_rdy_ == DISABLE_) &&
                 (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYC - 1));
`else
  assign abort = 1'b0;
`endif

  bus_addr_dec u_dec (
    .en  (accept),
    .idx (bif.req_addr[ADDR_W-1 -: SLV_SEL_W]),
    .cs_ (dec_cs_)
  );

  // Next-state and next-output logic; outputs hold unless an event occurs
  always_comb begin
    state_n = state;
    as_n    = as_q;
    cs_n    = cs_q;
    rw_n    = rw_q;
    addr_n  = addr_q;
    wd_n    = wd_q;
    busy_n  = busy_q;
    rv_n    = 1'b0;
    rd_n    = rd_q;
    err_n   = err_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_ACCESS;
          as_n    = ENABLE_;
          cs_n    = dec_cs_;
          rw_n    = bif.req_rw;
          addr_n  = bif.req_addr;
          wd_n    = bif.req_wr_data;
          busy_n  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (done || abort) begin
          state_n = ST_IDLE;
          as_n    = DISABLE_;
          cs_n    = {NUM_SLV{DISABLE_}};
          busy_n  = 1'b0;
          rv_n    = 1'b1;
          err_n   = !done;
          rd_n    = (done && (rw_q == READ)) ? bif.bus_rd_data : '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      as_q   <= DISABLE_;
      cs_q   <= {NUM_SLV{DISABLE_}};
      rw_q   <= READ;
      addr_q <= '0;
      wd_q   <= '0;
      busy_q <= 1'b0;
      rv_q   <= 1'b0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      as_q   <= as_n;
      cs_q   <= cs_n;
      rw_q   <= rw_n;
      addr_q <= addr_n;
      wd_q   <= wd_n;
      busy_q <= busy_n;
      rv_q   <= rv_n;
      rd_q   <= rd_n;
      err_q  <= err_n;
    end
  end

  assign bif.bus_as_      = as_q;
  assign bif.bus_cs_      = cs_q;
  assign bif.bus_rw       = rw_q;
  assign bif.bus_addr     = addr_q;
  assign bif.bus_wr_data  = wd_q;
  assign bif.req_busy     = busy_q;
  assign bif.resp_valid   = rv_q;
  assign bif.resp_rd_data = rd_q;
  assign bif.resp_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_bus_initiator                                         |
// | Purpose   : Scoreboard bench for bus_initiator with a responding     |
// |             slave model and randomized core traffic.                 |
// | Options   : BUS_TIMEOUT_EN - DUT built with TIMEOUT_CYC=4            |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_bus_initiator;
  import bus_pkg::*;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 1 << 30;
`endif
  localparam int SILENT = 100000;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    int                d;
    logic [DATA_W-1:0] rd;
  } req_t;

  typedef struct {
    logic [DATA_W-1:0] rd;
    logic              err;
    int                at;
  } rsp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   prev_resp = 0;

  req_t req_q[$];
  rsp_t exp_q[$];

  bus_initiator_if bif();

`ifdef BUS_TIMEOUT_EN
  bus_initiator #(.TIMEOUT_CYC(TMO)) dut (.clk(clk), .reset(reset), .bif(bif));
`else
  bus_initiator dut (.clk(clk), .reset(reset), .bif(bif));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Present a request at a negedge, wait for acceptance, record expectations.
  // Returns at the negedge following the accepting edge.
  task automatic issue(input logic rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input int d,
                       input logic [DATA_W-1:0] rd);
    int   waited;
    int   exp_acc;
    bit   err;
    rsp_t e;
    req_t r;
    waited = 0;
    bif.req = 1'b1;
    bif.req_rw = rw;
    bif.req_addr = a;
    bif.req_wr_data = wd;
    exp_acc = (cyc > prev_resp) ? cyc : prev_resp;
    while (bif.req_busy && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_cycle", cyc, exp_acc);
    err = (d >= TMO);
    prev_resp = cyc + (err ? (1 + TMO) : (2 + d));
    e.rd  = (err || rw == WRITE) ? '0 : rd;
    e.err = err;
    e.at  = prev_resp;
    exp_q.push_back(e);
    r.rw = rw; r.addr = a; r.wd = wd; r.d = d; r.rd = rd;
    req_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bif.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", bif.resp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rd_data", bif.resp_rd_data, e.rd);
          chk("resp_err", bif.resp_err, e.err);
          chk("resp_cycle", cyc, e.at);
        end
      end
    end
  end

  // Slave model: checks strobe contents and stability, answers after d cycles
  initial begin
    req_t               cur;
    int                 remaining;
    int                 slen;
    bit                 in_strobe;
    logic [NUM_SLV-1:0] exp_cs;
    in_strobe = 0;
    remaining = -1;
    slen = 0;
    bif.bus_rdy_ = 1'b1;
    bif.bus_rd_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_strobe = 0;
        bif.bus_rdy_ = 1'b1;
      end else if (bif.bus_as_ == 1'b0) begin
        if (!in_strobe) begin
          if (req_q.size() == 0) begin
            chk("unexpected_strobe", bif.bus_as_, 1);
            cur.rw = bif.bus_rw; cur.addr = bif.bus_addr; cur.wd = bif.bus_wr_data;
            cur.d = SILENT; cur.rd = '0;
          end else begin
            cur = req_q.pop_front();
          end
          in_strobe = 1;
          slen = 0;
          remaining = cur.d;
        end
        slen++;
        exp_cs = '1;
        exp_cs[cur.addr[ADDR_W-1 -: SLV_SEL_W]] = 1'b0;
        chk("strobe_cs_rw_addr", {bif.bus_cs_, bif.bus_rw, bif.bus_addr},
            {exp_cs, cur.rw, cur.addr});
        chk("strobe_wr_data", bif.bus_wr_data, cur.wd);
        if (remaining == 0) begin
          bif.bus_rdy_ = 1'b0;
          bif.bus_rd_data = cur.rd;
        end else begin
          bif.bus_rdy_ = 1'b1;
          bif.bus_rd_data = $urandom;
        end
        remaining--;
      end else begin
        if (in_strobe) begin
          chk("strobe_length", slen, (cur.d >= TMO) ? TMO : cur.d + 1);
          in_strobe = 0;
        end
        // Random rdy_ while idle must be ignored by the initiator
        bif.bus_rdy_ = 1'($urandom_range(0, 1));
        bif.bus_rd_data = $urandom;
      end
    end
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time bound reached");
  end

  // Stimulus
  initial begin
    logic              t_rw;
    logic [ADDR_W-1:0] t_a;
    logic [DATA_W-1:0] t_wd, t_rd;
    int                t_d, mode;

    bif.req = 1'b0;
    bif.req_rw = READ;
    bif.req_addr = '0;
    bif.req_wr_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_bus_as_", bif.bus_as_, 1);
    chk("rst_bus_cs_", bif.bus_cs_, 8'hFF);
    chk("rst_bus_rw", bif.bus_rw, READ);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_bus_wr_data", bif.bus_wr_data, 0);
    chk("rst_req_busy", bif.req_busy, 0);
    chk("rst_resp_valid", bif.resp_valid, 0);
    chk("rst_resp_rd_data", bif.resp_rd_data, 0);
    chk("rst_resp_err", bif.resp_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Read from slave 2, slave answers after one wait cycle
    issue(READ, 30'h1000_0003, $urandom, 1, 32'hDEAD_BEEF);
    chk("dir_cs_slave2", bif.bus_cs_, 8'hFB);
    bif.req = 1'b0;
    repeat (3) @(negedge clk);

    // Write 0xFF to slave 0 with a five cycle delay
    issue(WRITE, 30'h0000_0040, 32'h0000_00FF, 5, $urandom);
    chk("dir_cs_slave0", bif.bus_cs_, 8'hFE);
    bif.req = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back reads with req held high
    issue(READ, 30'h2345_6789, $urandom, 0, 32'h1234_5678);
    issue(READ, 30'h3FFF_FFFF, $urandom, 2, 32'hCAFE_F00D);
    bif.req = 1'b0;

    // req pulse while busy must be ignored
    issue(WRITE, 30'h0ABC_DEF0, 32'h5555_AAAA, 3, $urandom);
    bif.req_addr = 30'($urandom);
    bif.req_rw = READ;
    @(negedge clk);
    bif.req = 1'b0;
    repeat (6) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      t_rw = 1'($urandom_range(0, 1));
      t_a  = ADDR_W'($urandom);
      t_wd = $urandom;
      t_rd = $urandom;
      t_d  = $urandom_range(0, 6);
      issue(t_rw, t_a, t_wd, t_d, t_rd);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        bif.req_addr = ADDR_W'($urandom);
        bif.req_rw = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      if (mode != 0) begin
        bif.req = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    bif.req = 1'b0;
    drain();

`ifdef BUS_TIMEOUT_EN
    // Silent slave times out; rdy_ on the last wait cycle completes normally
    issue(READ, 30'h1800_0000, $urandom, SILENT, $urandom);
    bif.req = 1'b0;
    repeat (2) @(negedge clk);
    issue(READ, 30'h1800_0001, $urandom, TMO - 1, 32'h0F0F_0F0F);
    bif.req = 1'b0;
    drain();
`endif

    // Reset in the middle of an access
    issue(READ, 30'h3000_0005, $urandom, SILENT, $urandom);
    bif.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_bus_as_", bif.bus_as_, 1);
    chk("midrst_bus_cs_", bif.bus_cs_, 8'hFF);
    chk("midrst_req_busy", bif.req_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    req_q.delete();
    prev_resp = cyc;
    repeat (6) @(negedge clk);

    // Recovery after reset
    issue(WRITE, 30'h2000_0011, 32'hA5A5_5A5A, 2, $urandom);
    bif.req = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
